// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- multi-cycle ALU for the picoMIPS datapath
//
// Executes one of three operations per request, using a start/busy/done
// handshake toward the control FSM:
//   SUBLEQ (00) : wr_data = reg_2 - reg_1, branch = result <= 0   (1 cycle)
//   MULTI  (01) : signed fixed-point multiply reg_1 * immediate    (IMM_WIDTH+1 cycles)
//   ADDI   (10) : wr_data = reg_1 + sign-extended immediate        (1 cycle)
//   reserved(11): wr_data = 0, branch = 0                          (1 cycle)
// The multiply is a small iterative shift-add over operand magnitudes; the
// sign is reapplied once at the end so the most-negative operands work.
//
// Parameters
//   REG_WIDTH  register/result width (signed two's complement)
//   IMM_WIDTH  immediate width (signed); also the multiply iteration count
//   FRAC_BITS  fraction bits of MULTI, 0..IMM_WIDTH
//
// Ports
//   clk        in   system clock, rising edge
//   n_reset    in   asynchronous active-low reset
//   start      in   operation request, sampled only when idle
//   op_code    in   operation select
//   reg_1      in   operand A
//   reg_2      in   operand B
//   immediate  in   immediate operand
//   busy       out  operation in progress, start ignored
//   done       out  one-cycle pulse, wr_data/branch updated this cycle
//   wr_data    out  registered result, held until next completion
//   branch     out  registered branch flag, held with wr_data
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int REG_WIDTH = 8,
   parameter int IMM_WIDTH = 8,
   parameter int FRAC_BITS = 0
) (
   input  logic                 clk,
   input  logic                 n_reset,
   input  logic                 start,
   input  logic [1:0]           op_code,
   input  logic [REG_WIDTH-1:0] reg_1,
   input  logic [REG_WIDTH-1:0] reg_2,
   input  logic [IMM_WIDTH-1:0] immediate,
   output logic                 busy,
   output logic                 done,
   output logic [REG_WIDTH-1:0] wr_data,
   output logic                 branch
);

   // Full product width: wide enough for |reg_1| * |immediate| of either size.
   localparam int PW = 2 * ((REG_WIDTH > IMM_WIDTH) ? REG_WIDTH : IMM_WIDTH);
   localparam int CW = $clog2(IMM_WIDTH + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(IMM_WIDTH - 1);

   localparam logic [1:0] OP_SUBLEQ = 2'b00;
   localparam logic [1:0] OP_MULTI  = 2'b01;
   localparam logic [1:0] OP_ADDI   = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_FIN  = 2'b10
   } state_e;

   // Unsigned magnitude of a signed register-width value; the most-negative
   // value maps to 2**(REG_WIDTH-1), which still fits unsigned.
   function automatic logic [REG_WIDTH-1:0] abs_reg(input logic [REG_WIDTH-1:0] v);
      logic [REG_WIDTH-1:0] r;
      if (v[REG_WIDTH-1]) begin
         r = ~v + REG_WIDTH'(1);
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Unsigned magnitude of a signed immediate-width value.
   function automatic logic [IMM_WIDTH-1:0] abs_imm(input logic [IMM_WIDTH-1:0] v);
      logic [IMM_WIDTH-1:0] r;
      if (v[IMM_WIDTH-1]) begin
         r = ~v + IMM_WIDTH'(1);
      end else begin
         r = v;
      end
      return r;
   endfunction

   state_e               state_q,   state_d;
   logic [CW-1:0]        cnt_q,     cnt_d;
   logic [PW-1:0]        acc_q,     acc_d;
   logic [PW-1:0]        mcand_q,   mcand_d;
   logic [IMM_WIDTH-1:0] mplr_q,    mplr_d;
   logic                 sign_q,    sign_d;
   logic                 busy_q,    busy_d;
   logic                 done_q,    done_d;
   logic [REG_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                 branch_q,  branch_d;

   logic [REG_WIDTH-1:0] imm_ext_s;
   logic [REG_WIDTH-1:0] sub_res_s;
   logic                 sub_le0_s;
   logic [REG_WIDTH-1:0] add_res_s;

   // Immediate resized to register width: sign-extend when narrower, truncate otherwise.
   generate
      if (IMM_WIDTH >= REG_WIDTH) begin : g_imm_trunc
         assign imm_ext_s = immediate[REG_WIDTH-1:0];
      end else begin : g_imm_sext
         assign imm_ext_s = {{(REG_WIDTH-IMM_WIDTH){immediate[IMM_WIDTH-1]}}, immediate};
      end
   endgenerate

   assign sub_res_s = reg_2 - reg_1;
   assign sub_le0_s = sub_res_s[REG_WIDTH-1] | ~(|sub_res_s);
   assign add_res_s = reg_1 + imm_ext_s;

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= {CW{1'b0}};
         acc_q     <= {PW{1'b0}};
         mcand_q   <= {PW{1'b0}};
         mplr_q    <= {IMM_WIDTH{1'b0}};
         sign_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_data_q <= {REG_WIDTH{1'b0}};
         branch_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         sign_q    <= sign_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wr_data_q <= wr_data_d;
         branch_q  <= branch_d;
      end
   end

   // Next-state, datapath and output computation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      sign_d    = sign_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      wr_data_d = wr_data_q;
      branch_d  = branch_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op_code)
                  OP_SUBLEQ: begin
                     wr_data_d = sub_res_s;
                     branch_d  = sub_le0_s;
                     done_d    = 1'b1;
                  end
                  OP_ADDI: begin
                     wr_data_d = add_res_s;
                     branch_d  = 1'b0;
                     done_d    = 1'b1;
                  end
                  OP_MULTI: begin
                     // Multiplicand sits in the low bits and shifts left each
                     // iteration; multiplier bits are consumed LSB first.
                     mcand_d = {{(PW-REG_WIDTH){1'b0}}, abs_reg(reg_1)};
                     mplr_d  = abs_imm(immediate);
                     sign_d  = reg_1[REG_WIDTH-1] ^ immediate[IMM_WIDTH-1];
                     acc_d   = {PW{1'b0}};
                     cnt_d   = {CW{1'b0}};
                     busy_d  = 1'b1;
                     state_d = S_MUL;
                  end
                  default: begin
                     wr_data_d = {REG_WIDTH{1'b0}};
                     branch_d  = 1'b0;
                     done_d    = 1'b1;
                  end
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end

         S_MUL: begin
            if (mplr_q[0]) begin
               acc_d = acc_q + mcand_q;
            end else begin
               acc_d = acc_q;
            end
            mcand_d = mcand_q << 1'b1;
            mplr_d  = mplr_q >> 1'b1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIN;
            end else begin
               state_d = S_MUL;
            end
         end

         S_FIN: begin
            // Reapply the sign to the full product, then take the
            // REG_WIDTH-bit window starting at FRAC_BITS (upper bits wrap away).
            wr_data_d = REG_WIDTH'((sign_q ? (~acc_q + PW'(1)) : acc_q) >> FRAC_BITS);
            branch_d  = 1'b0;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign wr_data = wr_data_q;
   assign branch  = branch_q;

endmodule
